// File: rtl/fetch_unit_if.sv
// Fetch-unit bus: instruction-memory request/response channel, execute redirect
// and the decoder-side instruction handshake.
interface fetch_unit_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] instruction;
  logic [31:0] inst_pc;

  modport master (
    output imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr, inst_valid, instruction, inst_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect, redirect_pc, inst_ready
  );
endinterface

// File: rtl/fetch_unit.sv
// In-order instruction fetch: credit-gated requests, in-order response FIFO,
// redirect flush with counted discard of stale in-flight responses.
module fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input logic          clk,
  input logic          rst,
  fetch_unit_if.master bus
);

  localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  typedef logic [PW-1:0] ptr_t;
  typedef logic [2:0]    cnt_t;

  function automatic ptr_t next_ptr(input ptr_t p);
    return (p == ptr_t'(MAX_OUTSTANDING - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  logic [31:0] pc;
  logic [31:0] fifo_data [MAX_OUTSTANDING];
  logic [31:0] fifo_pc   [MAX_OUTSTANDING];
  logic [31:0] pend_pc   [MAX_OUTSTANDING];
  ptr_t        fifo_rd, fifo_wr, pend_rd, pend_wr;
  cnt_t        fifo_count, inflight, drop;
  cnt_t        fifo_count_nxt, inflight_nxt;

  logic req_fire, rsp, push, pop;

  assign bus.imem_req_addr  = pc;
  assign bus.imem_req_valid = !rst && !bus.redirect &&
                              (({1'b0, inflight} + {1'b0, fifo_count}) < 4'(MAX_OUTSTANDING));
  assign bus.inst_valid     = (fifo_count != '0) && !bus.redirect;
  assign bus.instruction    = fifo_data[fifo_rd];
  assign bus.inst_pc        = fifo_pc[fifo_rd];

  assign req_fire = bus.imem_req_valid && bus.imem_req_ready;
  assign rsp      = bus.imem_rsp_valid;
  assign push     = rsp && !bus.redirect && (drop == '0);
  assign pop      = bus.inst_valid && bus.inst_ready;

  always_comb begin
    inflight_nxt = inflight;
    if (req_fire) inflight_nxt = inflight_nxt + cnt_t'(1);
    if (rsp)      inflight_nxt = inflight_nxt - cnt_t'(1);
    fifo_count_nxt = fifo_count;
    if (push) fifo_count_nxt = fifo_count_nxt + cnt_t'(1);
    if (pop)  fifo_count_nxt = fifo_count_nxt - cnt_t'(1);
  end

  // Every response, kept or dropped, retires one pending address so the
  // address queue stays aligned with the memory's in-order return stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= {RESET_PC[31:2], 2'b00};
      fifo_rd    <= '0;
      fifo_wr    <= '0;
      fifo_count <= '0;
      pend_rd    <= '0;
      pend_wr    <= '0;
      inflight   <= '0;
      drop       <= '0;
    end else begin
      inflight <= inflight_nxt;
      if (req_fire) begin
        pc      <= pc + 32'd4;
        pend_wr <= next_ptr(pend_wr);
      end
      if (rsp) pend_rd <= next_ptr(pend_rd);
      if (bus.redirect) begin
        pc         <= {bus.redirect_pc[31:2], 2'b00};
        fifo_rd    <= '0;
        fifo_wr    <= '0;
        fifo_count <= '0;
        drop       <= rsp ? inflight - cnt_t'(1) : inflight;
      end else begin
        if (rsp && (drop != '0)) drop <= drop - cnt_t'(1);
        if (push) fifo_wr <= next_ptr(fifo_wr);
        if (pop)  fifo_rd <= next_ptr(fifo_rd);
        fifo_count <= fifo_count_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) pend_pc[pend_wr] <= pc;
    if (push) begin
      fifo_data[fifo_wr] <= bus.imem_rsp_data;
      fifo_pc[fifo_wr]   <= pend_pc[pend_rd];
    end
  end

endmodule
